// File: rtl/raster_cmd_queue_if.sv
// Command output bus from the assembler queue to the raster engine.
// The queue drives the head command and valid; the consumer drives ready.
interface raster_cmd_queue_if #(
  parameter int COORD_W = 3
);
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         out_op;
  logic [COORD_W-1:0] out_x1;
  logic [COORD_W-1:0] out_y1;
  logic [COORD_W-1:0] out_x2;
  logic [COORD_W-1:0] out_y2;
  logic [COORD_W-1:0] out_w;
  logic [COORD_W-1:0] out_h;

  modport master (
    output out_valid, out_op, out_x1, out_y1, out_x2, out_y2, out_w, out_h,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_op, out_x1, out_y1, out_x2, out_y2, out_w, out_h,
    output out_ready
  );
endinterface

// File: rtl/raster_cmd_queue.sv
// Byte-serial rasterizer command assembler feeding a DEPTH-entry fall-through FIFO; a command is at the head one cycle after its last byte.
// Backpressure via out_valid/out_ready; a command completing into a full FIFO with no pop that cycle is dropped and flagged on err_ovf.
module raster_cmd_queue #(
  parameter int COORD_W = 3,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   ui_in,
  raster_cmd_queue_if.master           bus,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         busy,
  output logic                         err_proto,
  output logic                         err_ovf
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  localparam logic [2:0] OP_LINE  = 3'd2;
  localparam logic [2:0] OP_PIXEL = 3'd1;
  localparam logic [2:0] OP_CLEAR = 3'd4;

  typedef struct packed {
    logic [2:0]         op;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
  } cmd_t;

  typedef enum logic {S_IDLE = 1'b0, S_COLLECT = 1'b1} state_t;

  state_t r_state, w_nstate;
  logic [1:0] r_cnt, w_cnt_n;
  cmd_t r_cur, w_cur_n, w_ent;
  logic w_push, w_err_proto;

  cmd_t r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic r_err_proto, r_err_ovf;

  logic w_is_op, w_is_par, w_is_clear, w_last;
  logic [COORD_W-1:0] w_par;
  logic w_vld, w_full, w_pop, w_wr, w_ovf;
  cmd_t w_head;

  assign w_is_op    = ui_in[7] && (ui_in[6:5] != 2'b00);
  assign w_is_par   = ui_in[7] && (ui_in[6:5] == 2'b00);
  assign w_is_clear = ui_in[7] && (ui_in[6:0] == 7'h3F);
  assign w_par      = ui_in[COORD_W-1:0];
  // PIXEL needs one parameter byte, LINE/RECT need three.
  assign w_last     = (r_cur.op == OP_PIXEL) || (r_cnt == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cur   <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_cnt_n;
      r_cur   <= w_cur_n;
    end
  end

  always_comb begin
    w_nstate    = r_state;
    w_cnt_n     = r_cnt;
    w_cur_n     = r_cur;
    w_ent       = '0;
    w_push      = 1'b0;
    w_err_proto = 1'b0;
    if (w_is_op) begin
      // An opcode mid-command aborts it and is decoded as a fresh opcode.
      w_err_proto = (r_state == S_COLLECT);
      w_cnt_n     = '0;
      if (w_is_clear) begin
        w_push   = 1'b1;
        w_ent.op = OP_CLEAR;
        w_nstate = S_IDLE;
      end else begin
        w_cur_n    = '0;
        w_cur_n.op = {1'b0, ui_in[6:5]};
        w_cur_n.x1 = w_par;
        w_nstate   = S_COLLECT;
      end
    end else if (w_is_par) begin
      if (r_state == S_IDLE) begin
        w_err_proto = 1'b1;
      end else begin
        case (r_cnt)
          2'd0:    w_cur_n.y1 = w_par;
          2'd1:    if (r_cur.op == OP_LINE) w_cur_n.x2 = w_par; else w_cur_n.w = w_par;
          default: if (r_cur.op == OP_LINE) w_cur_n.y2 = w_par; else w_cur_n.h = w_par;
        endcase
        w_cnt_n = r_cnt + 2'd1;
        if (w_last) begin
          w_push   = 1'b1;
          w_ent    = w_cur_n;
          w_nstate = S_IDLE;
          w_cnt_n  = '0;
        end
      end
    end
  end

  assign w_vld  = (r_level != '0);
  assign w_full = (r_level == FULL_LVL);
  assign w_pop  = w_vld && bus.out_ready;
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_ovf  = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_err_proto <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_level     <= r_level + LW'(w_wr) - LW'(w_pop);
      r_err_proto <= w_err_proto;
      r_err_ovf   <= w_ovf;
    end
  end

  assign w_head        = w_vld ? r_mem[r_rptr] : '0;
  assign bus.out_valid = w_vld;
  assign bus.out_op    = w_head.op;
  assign bus.out_x1    = w_head.x1;
  assign bus.out_y1    = w_head.y1;
  assign bus.out_x2    = w_head.x2;
  assign bus.out_y2    = w_head.y2;
  assign bus.out_w     = w_head.w;
  assign bus.out_h     = w_head.h;

  assign level     = r_level;
  assign busy      = (r_state == S_COLLECT);
  assign err_proto = r_err_proto;
  assign err_ovf   = r_err_ovf;
endmodule

// File: tb/tb_raster_cmd_queue.sv
// Scoreboard bench for raster_cmd_queue: expected commands are queued when their completing byte is driven and compared on each pop.
module tb_raster_cmd_queue;
  localparam int CW    = 3;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [2:0]    op;
    logic [CW-1:0] x1;
    logic [CW-1:0] y1;
    logic [CW-1:0] x2;
    logic [CW-1:0] y2;
    logic [CW-1:0] w;
    logic [CW-1:0] h;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    ui_in = 8'h00;
  logic [LW-1:0] level;
  logic          busy, err_proto, err_ovf;

  raster_cmd_queue_if #(.COORD_W(CW)) bus ();

  raster_cmd_queue #(.COORD_W(CW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ui_in     (ui_in),
    .bus       (bus),
    .level     (level),
    .busy      (busy),
    .err_proto (err_proto),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_proto = 0;
  int   n_ovf   = 0;
  int   exp_ovf = 0;
  ent_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input int op, input int x1, input int y1,
                              input int x2, input int y2, input int w, input int h);
    ent_t e;
    e.op = 3'(op);
    e.x1 = CW'(x1); e.y1 = CW'(y1); e.x2 = CW'(x2);
    e.y2 = CW'(y2); e.w = CW'(w);   e.h = CW'(h);
    return e;
  endfunction

  function automatic ent_t head();
    ent_t e;
    e.op = bus.out_op;
    e.x1 = bus.out_x1; e.y1 = bus.out_y1; e.x2 = bus.out_x2;
    e.y2 = bus.out_y2; e.w = bus.out_w;   e.h = bus.out_h;
    return e;
  endfunction

  // Called just before the completing byte is driven; decides accept vs drop.
  task automatic exp_push(input ent_t e);
    if (sb.size() >= DEPTH && !bus.out_ready) exp_ovf++;
    else sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    ui_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(8'h00);
  endtask

  task automatic drain();
    int k;
    bus.out_ready = 1'b1;
    k = 0;
    while ((level != '0) && (k < 20)) begin
      send(8'h00);
      k++;
    end
    if (k >= 20) chk("drain_timeout", 32'd1, 32'd0);
    bus.out_ready = 1'b0;
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("empty_out_zero", 32'(head()), 32'd0);
  endtask

  // Pop side of the scoreboard; the DUT pops on the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_proto) n_proto++;
      if (err_ovf)   n_ovf++;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) chk("pop_unexpected", 32'(head()), 32'd0);
        else chk("pop_head", 32'(head()), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    int p0;
    int o0;
    bus.out_ready = 1'b0;
    #23;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_errs",  32'({err_proto, err_ovf}), 32'd0);
    chk("rst_head",  32'(head()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // PIXEL with consumer ready
    bus.out_ready = 1'b1;
    send(8'hA3);
    chk("pix_busy", 32'(busy), 32'd1);
    exp_push(mk(1, 3, 5, 0, 0, 0, 0));
    send(8'h85);
    chk("pix_level1", 32'(level), 32'd1);
    chk("pix_head", 32'(head()), 32'(mk(1, 3, 5, 0, 0, 0, 0)));
    chk("pix_busy0", 32'(busy), 32'd0);
    send(8'h00);
    chk("pix_level0", 32'(level), 32'd0);
    bus.out_ready = 1'b0;

    // LINE then RECT held in the FIFO
    p0 = n_proto;
    send(8'hC1); send(8'h82); send(8'h86);
    exp_push(mk(2, 1, 2, 6, 7, 0, 0));
    send(8'h87);
    send(8'hE0); send(8'h81); send(8'h84);
    exp_push(mk(3, 0, 1, 0, 0, 4, 3));
    send(8'h83);
    idle(1);
    chk("lr_level2", 32'(level), 32'd2);
    chk("lr_head_line", 32'(head()), 32'(mk(2, 1, 2, 6, 7, 0, 0)));
    idle(1);
    chk("lr_head_stable", 32'(head()), 32'(mk(2, 1, 2, 6, 7, 0, 0)));
    bus.out_ready = 1'b1;
    send(8'h00);
    bus.out_ready = 1'b0;
    chk("lr_level1", 32'(level), 32'd1);
    chk("lr_head_rect", 32'(head()), 32'(mk(3, 0, 1, 0, 0, 4, 3)));
    drain();
    chk("lr_no_proto", 32'(n_proto - p0), 32'd0);

    // Abort LINE with CLEAR
    p0 = n_proto;
    send(8'hC2); send(8'h81);
    exp_push(mk(4, 0, 0, 0, 0, 0, 0));
    send(8'hBF);
    chk("abort_busy0", 32'(busy), 32'd0);
    idle(1);
    chk("abort_proto", 32'(n_proto - p0), 32'd1);
    chk("abort_level", 32'(level), 32'd1);
    chk("abort_head", 32'(head()), 32'(mk(4, 0, 0, 0, 0, 0, 0)));
    drain();

    // en=0 gap inside PIXEL
    p0 = n_proto;
    bus.out_ready = 1'b1;
    send(8'hA6);
    for (int i = 0; i < 3; i++) begin
      send(8'h00);
      chk("gap_busy", 32'(busy), 32'd1);
    end
    exp_push(mk(1, 6, 4, 0, 0, 0, 0));
    send(8'h84);
    idle(2);
    chk("gap_proto", 32'(n_proto - p0), 32'd0);
    drain();

    // Overflow without pop
    o0 = n_ovf;
    for (int i = 0; i < DEPTH + 1; i++) begin
      exp_push(mk(4, 0, 0, 0, 0, 0, 0));
      send(8'hBF);
    end
    idle(1);
    chk("ovf_level", 32'(level), 32'(DEPTH));
    chk("ovf_pulse", 32'(n_ovf - o0), 32'd1);
    chk("ovf_model", 32'(n_ovf), 32'(exp_ovf));
    drain();

    // Full with a simultaneous pop
    o0 = n_ovf;
    for (int i = 0; i < DEPTH; i++) begin
      exp_push(mk(4, 0, 0, 0, 0, 0, 0));
      send(8'hBF);
    end
    bus.out_ready = 1'b1;
    exp_push(mk(4, 0, 0, 0, 0, 0, 0));
    send(8'hBF);
    bus.out_ready = 1'b0;
    chk("fullpop_level", 32'(level), 32'(DEPTH));
    idle(1);
    chk("fullpop_no_ovf", 32'(n_ovf - o0), 32'd0);
    drain();

    // Stray parameter byte in IDLE
    p0 = n_proto;
    send(8'h85);
    idle(1);
    chk("stray_proto", 32'(n_proto - p0), 32'd1);
    chk("stray_level", 32'(level), 32'd0);

    // Reset mid-LINE with an entry queued
    exp_push(mk(4, 0, 0, 0, 0, 0, 0));
    send(8'hBF);
    send(8'hC1); send(8'h82);
    ui_in = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mrst_level", 32'(level), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_head", 32'(head()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'hA1);
    exp_push(mk(1, 1, 2, 0, 0, 0, 0));
    send(8'h82);
    chk("mrst_pix", 32'(head()), 32'(mk(1, 1, 2, 0, 0, 0, 0)));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
